// File: rtl/pixel_stream_pkg.sv
// ============================================================================
// Module : pixel_stream_pkg
// Brief  : Shared types and defaults for the frame-to-UART pixel path.
//          FRAME_HEADER_EN adds the two header states to sched_state_t.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pixel_stream_pkg;

    localparam int                   C_PIXEL_W      = 12;
    localparam logic [C_PIXEL_W-1:0] C_SYNC_WORD    = 12'hABC;
    localparam int                   C_FRAME_PIXELS = 320 * 240;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
`ifdef FRAME_HEADER_EN
        ST_HDR_SYNC = 3'd1,
        ST_HDR_CNT  = 3'd2,
`endif
        ST_FETCH    = 3'd3,
        ST_LOAD     = 3'd4,
        ST_SEND     = 3'd5,
        ST_DONE     = 3'd6
    } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/frame_addr_counter.sv
// ============================================================================
// Module : frame_addr_counter
// Brief  : Frame-buffer address register with clear, increment and last flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module frame_addr_counter
    import pixel_stream_pkg::*;
#(
    parameter int ADDR_W       = 17,
    parameter int FRAME_PIXELS = C_FRAME_PIXELS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

    logic [ADDR_W-1:0] r_addr;

    // Clear has priority so an abort on a mid-frame transfer rewinds to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
        end else if (i_clr) begin
            r_addr <= '0;
        end else if (i_inc) begin
            r_addr <= r_addr + 1'b1;
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_addr == C_LAST_ADDR);

endmodule

`default_nettype wire

// File: rtl/pixel_frame_scheduler.sv
// ============================================================================
// Module : pixel_frame_scheduler
// Brief  : Streams one frame (or continuous frames) from the frame buffer to
//          send_pixel. Optional per-frame header: define FRAME_HEADER_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pixel_frame_scheduler
    import pixel_stream_pkg::*;
#(
    parameter int                 IMAGE_WIDTH  = 320,
    parameter int                 IMAGE_HEIGHT = 240,
    parameter int                 PIXEL_W      = C_PIXEL_W,
    parameter int                 ADDR_W       = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT),
    parameter logic [PIXEL_W-1:0] SYNC_WORD    = PIXEL_W'(C_SYNC_WORD)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               continuous,
    input  logic               abort,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [PIXEL_W-1:0] rd_data,
    output logic [PIXEL_W-1:0] pixel,
    output logic               valid_out,
    input  logic               ready_in,
    output logic               busy,
    output logic               frame_done,
    output logic [7:0]         frames_sent
);

    localparam int C_FRAME_PIXELS_LOCAL = IMAGE_WIDTH * IMAGE_HEIGHT;

`ifdef FRAME_HEADER_EN
    localparam sched_state_t C_FIRST_STATE = ST_HDR_SYNC;
`else
    localparam sched_state_t C_FIRST_STATE = ST_FETCH;
`endif

    sched_state_t       r_state;
    sched_state_t       w_next;
    logic               r_abort;
    logic               r_valid_out;
    logic               r_busy;
    logic               r_frame_done;
    logic [7:0]         r_frames_sent;
    logic [PIXEL_W-1:0] r_pixel;
    logic               w_abort_req;
    logic               w_xfer;
    logic               w_last;
    logic               w_addr_clr;
    logic               w_addr_inc;

    // An abort raised in the very cycle it is honoured must still take effect.
    assign w_abort_req = r_abort | abort;
    assign w_xfer      = r_valid_out & ready_in;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_next = C_FIRST_STATE;
                end
            end
`ifdef FRAME_HEADER_EN
            ST_HDR_SYNC: begin
                if (w_xfer) begin
                    w_next = w_abort_req ? ST_IDLE : ST_HDR_CNT;
                end
            end
            ST_HDR_CNT: begin
                if (w_xfer) begin
                    w_next = w_abort_req ? ST_IDLE : ST_FETCH;
                end
            end
`endif
            ST_FETCH: w_next = w_abort_req ? ST_IDLE : ST_LOAD;
            ST_LOAD:  w_next = ST_SEND;
            ST_SEND: begin
                if (w_xfer) begin
                    if (w_abort_req) begin
                        w_next = ST_IDLE;
                    end else if (w_last) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next = ST_FETCH;
                    end
                end
            end
            ST_DONE: w_next = (w_abort_req || !continuous) ? ST_IDLE : C_FIRST_STATE;
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_addr_clr = (w_next == ST_IDLE) || (r_state == ST_DONE);
    assign w_addr_inc = (r_state == ST_SEND) && w_xfer && !w_last;

    frame_addr_counter #(
        .ADDR_W       (ADDR_W),
        .FRAME_PIXELS (C_FRAME_PIXELS_LOCAL)
    ) u_addr (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_addr_clr),
        .i_inc  (w_addr_inc),
        .o_addr (rd_addr),
        .o_last (w_last)
    );

    // Status outputs are registered from the next-state decode so they line up
    // with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_abort       <= 1'b0;
            r_valid_out   <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frames_sent <= 8'd0;
            r_pixel       <= '0;
        end else begin
            r_state      <= w_next;
            r_busy       <= (w_next != ST_IDLE);
            r_frame_done <= (w_next == ST_DONE);
`ifdef FRAME_HEADER_EN
            r_valid_out  <= (w_next == ST_SEND) || (w_next == ST_HDR_SYNC) ||
                            (w_next == ST_HDR_CNT);
`else
            r_valid_out  <= (w_next == ST_SEND);
`endif
            if (w_next == ST_IDLE) begin
                r_abort <= 1'b0;
            end else if (abort) begin
                r_abort <= 1'b1;
            end
            if (w_next == ST_DONE) begin
                r_frames_sent <= r_frames_sent + 8'd1;
            end
            if (r_state == ST_LOAD) begin
                r_pixel <= rd_data;
            end
`ifdef FRAME_HEADER_EN
            else if (w_next == ST_HDR_SYNC && r_state != ST_HDR_SYNC) begin
                r_pixel <= SYNC_WORD;
            end else if (w_next == ST_HDR_CNT && r_state == ST_HDR_SYNC) begin
                r_pixel <= PIXEL_W'(r_frames_sent);
            end
`endif
        end
    end

    assign rd_en       = (r_state == ST_FETCH);
    assign pixel       = r_pixel;
    assign valid_out   = r_valid_out;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign frames_sent = r_frames_sent;

endmodule

`default_nettype wire

// File: tb/tb_pixel_frame_scheduler.sv
// ============================================================================
// Module : tb_pixel_frame_scheduler
// Brief  : Self-checking bench for pixel_frame_scheduler on a 4x2 frame.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pixel_frame_scheduler;
    import pixel_stream_pkg::*;

    localparam int C_W      = 4;
    localparam int C_H      = 2;
    localparam int C_NPIX   = C_W * C_H;
    localparam int C_PW     = 12;
    localparam int C_AW     = $clog2(C_NPIX);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            continuous = 1'b0;
    logic            abort = 1'b0;
    logic            rd_en;
    logic [C_AW-1:0] rd_addr;
    logic [C_PW-1:0] rd_data = '0;
    logic [C_PW-1:0] pixel;
    logic            valid_out;
    logic            ready_in = 1'b0;
    logic            busy;
    logic            frame_done;
    logic [7:0]      frames_sent;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int stab_viol = 0;
    int exp_frames = 0;
    logic [C_PW-1:0] got[$];
    logic [C_PW-1:0] exp_q[$];
    logic            prev_stall = 1'b0;
    logic [C_PW-1:0] prev_pix = '0;

    pixel_frame_scheduler #(
        .IMAGE_WIDTH  (C_W),
        .IMAGE_HEIGHT (C_H),
        .PIXEL_W      (C_PW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .continuous  (continuous),
        .abort       (abort),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .pixel       (pixel),
        .valid_out   (valid_out),
        .ready_in    (ready_in),
        .busy        (busy),
        .frame_done  (frame_done),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    // Frame buffer: one-cycle read latency, content 0x100 + address.
    always @(posedge clk) begin
        if (rd_en) rd_data <= 12'h100 + C_PW'(rd_addr);
    end

    // Inputs only change 1 time unit after a rising edge, so the negedge view
    // equals what the next rising edge sees.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!valid_out || pixel !== prev_pix)) stab_viol++;
            if (valid_out && ready_in) got.push_back(pixel);
            if (frame_done) done_cnt++;
            prev_stall = valid_out && !ready_in;
            prev_pix   = pixel;
        end
    end

    // Reference: one frame is optional header then npix buffer words in order.
    task automatic add_frame(input int cnt, input int npix);
`ifdef FRAME_HEADER_EN
        exp_q.push_back(12'hABC);
        exp_q.push_back(C_PW'(cnt % 256));
`endif
        for (int a = 0; a < npix; a++) exp_q.push_back(C_PW'(12'h100 + a));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_checks++;
        if ({rd_en, rd_addr, pixel, valid_out, busy, frame_done, frames_sent} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs got rd_en=%b addr=%0d pix=%h v=%b busy=%b fd=%b fs=%0d want all 0",
                     rd_en, rd_addr, pixel, valid_out, busy, frame_done, frames_sent);
        end
        rst = 1'b0;
        exp_frames = 0;
        tick(); tick();
        n_checks++;
        if (busy !== 1'b0 || valid_out !== 1'b0 || frames_sent !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_idle got busy=%b v=%b fs=%0d want 0 0 0", busy, valid_out, frames_sent);
        end
    endtask

    task automatic test_single_frame();
        int base;
        int cyc;
        got.delete(); exp_q.delete();
        base = done_cnt;
        add_frame(exp_frames, C_NPIX);
        ready_in = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef FRAME_HEADER_EN
        n_checks++;
        if (valid_out !== 1'b1 || pixel !== 12'hABC) begin
            n_errors++;
            $display("FAIL latency_hdr got v=%b pix=%h want 1 abc", valid_out, pixel);
        end
`else
        n_checks++;
        if (rd_en !== 1'b1 || rd_addr !== '0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL latency_fetch got rd_en=%b addr=%0d busy=%b want 1 0 1", rd_en, rd_addr, busy);
        end
        tick();
        n_checks++;
        if (rd_en !== 1'b0 || valid_out !== 1'b0) begin
            n_errors++;
            $display("FAIL latency_load got rd_en=%b v=%b want 0 0", rd_en, valid_out);
        end
        tick();
        n_checks++;
        if (valid_out !== 1'b1 || pixel !== 12'h100) begin
            n_errors++;
            $display("FAIL latency_send got v=%b pix=%h want 1 100", valid_out, pixel);
        end
`endif
        cyc = 0;
        while (done_cnt == base && cyc < 200) begin tick(); cyc++; end
        tick(); tick();
        n_checks++;
        if (got.size() !== exp_q.size()) begin
            n_errors++;
            $display("FAIL single_len got %0d want %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL single_word[%0d] got %h want %h", i, got[i], exp_q[i]);
            end
        end
        exp_frames++;
        n_checks++;
        if (done_cnt - base !== 1 || frames_sent !== 8'(exp_frames) || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL single_end got done=%0d fs=%0d busy=%b want 1 %0d 0",
                     done_cnt - base, frames_sent, busy, exp_frames);
        end
    endtask

    task automatic test_backpressure();
        int base;
        int cyc;
        got.delete(); exp_q.delete();
        base = done_cnt;
        stab_viol = 0;
        add_frame(exp_frames, C_NPIX);
        ready_in = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (done_cnt == base && cyc < 600) begin
            ready_in = ($urandom_range(0, 1) == 1);
            tick();
            cyc++;
        end
        ready_in = 1'b1;
        tick(); tick();
        n_checks++;
        if (stab_viol !== 0) begin
            n_errors++;
            $display("FAIL bp_stable got %0d violations want 0", stab_viol);
        end
        n_checks++;
        if (got.size() !== exp_q.size()) begin
            n_errors++;
            $display("FAIL bp_len got %0d want %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL bp_word[%0d] got %h want %h", i, got[i], exp_q[i]);
            end
        end
        exp_frames++;
        n_checks++;
        if (frames_sent !== 8'(exp_frames) || done_cnt - base !== 1) begin
            n_errors++;
            $display("FAIL bp_end got fs=%0d done=%0d want %0d 1", frames_sent, done_cnt - base, exp_frames);
        end
    endtask

    task automatic test_continuous();
        int base;
        int cyc;
        int idle_seen;
        got.delete(); exp_q.delete();
        base = done_cnt;
        for (int k = 0; k < 3; k++) add_frame(exp_frames + k, C_NPIX);
        continuous = 1'b1;
        ready_in = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        idle_seen = 0;
        while (done_cnt - base < 3 && cyc < 400) begin
            if (!busy) idle_seen++;
            if (done_cnt - base >= 2) continuous = 1'b0;
            tick();
            cyc++;
        end
        continuous = 1'b0;
        tick(); tick();
        n_checks++;
        if (idle_seen !== 0) begin
            n_errors++;
            $display("FAIL cont_no_gap got %0d idle cycles want 0", idle_seen);
        end
        n_checks++;
        if (got.size() !== exp_q.size()) begin
            n_errors++;
            $display("FAIL cont_len got %0d want %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL cont_word[%0d] got %h want %h", i, got[i], exp_q[i]);
            end
        end
        exp_frames += 3;
        n_checks++;
        if (frames_sent !== 8'(exp_frames) || busy !== 1'b0 || done_cnt - base !== 3) begin
            n_errors++;
            $display("FAIL cont_end got fs=%0d busy=%b done=%0d want %0d 0 3",
                     frames_sent, busy, done_cnt - base, exp_frames);
        end
    endtask

    task automatic test_abort();
        int base;
        int cyc;
        logic found;
        got.delete(); exp_q.delete();
        base = done_cnt;
        add_frame(exp_frames, 4);
        ready_in = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        cyc = 0;
        while (!found && cyc < 100) begin
            if (valid_out && pixel == 12'h103) found = 1'b1;
            else begin tick(); cyc++; end
        end
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL abort_reach got no 0x103 within %0d cycles want 0x103 valid", cyc);
        end
        ready_in = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick(); tick();
        n_checks++;
        if (valid_out !== 1'b1 || pixel !== 12'h103) begin
            n_errors++;
            $display("FAIL abort_hold got v=%b pix=%h want 1 103", valid_out, pixel);
        end
        ready_in = 1'b1;
        cyc = 0;
        while (busy && cyc < 20) begin tick(); cyc++; end
        tick(); tick();
        n_checks++;
        if (got.size() !== exp_q.size()) begin
            n_errors++;
            $display("FAIL abort_len got %0d want %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL abort_word[%0d] got %h want %h", i, got[i], exp_q[i]);
            end
        end
        n_checks++;
        if (done_cnt !== base || frames_sent !== 8'(exp_frames) || busy !== 1'b0 || valid_out !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_end got done=%0d fs=%0d busy=%b v=%b want 0 %0d 0 0",
                     done_cnt - base, frames_sent, busy, valid_out, exp_frames);
        end
    endtask

    task automatic test_start_abort_same();
        int busy_seen;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy || rd_en || valid_out) busy_seen++;
            tick();
        end
        n_checks++;
        if (busy_seen !== 0) begin
            n_errors++;
            $display("FAIL start_abort got %0d active cycles want 0", busy_seen);
        end
    endtask

    task automatic test_reset_mid_frame();
        int base;
        int cyc;
        logic found;
        ready_in = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        cyc = 0;
        while (!found && cyc < 100) begin
            if (valid_out && pixel == 12'h105) found = 1'b1;
            else begin tick(); cyc++; end
        end
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL rstmid_reach got no 0x105 within %0d cycles want 0x105 valid", cyc);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({rd_en, rd_addr, pixel, valid_out, busy, frame_done, frames_sent} !== '0) begin
            n_errors++;
            $display("FAIL rstmid_async got rd_en=%b addr=%0d pix=%h v=%b busy=%b fd=%b fs=%0d want all 0",
                     rd_en, rd_addr, pixel, valid_out, busy, frame_done, frames_sent);
        end
        tick();
        rst = 1'b0;
        exp_frames = 0;
        tick();
        got.delete(); exp_q.delete();
        base = done_cnt;
        add_frame(exp_frames, C_NPIX);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (done_cnt == base && cyc < 200) begin tick(); cyc++; end
        tick(); tick();
        n_checks++;
        if (got.size() !== exp_q.size()) begin
            n_errors++;
            $display("FAIL rstmid_len got %0d want %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL rstmid_word[%0d] got %h want %h", i, got[i], exp_q[i]);
            end
        end
        exp_frames++;
        n_checks++;
        if (frames_sent !== 8'(exp_frames) || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL rstmid_end got fs=%0d busy=%b want %0d 0", frames_sent, busy, exp_frames);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_continuous();
        test_abort();
        test_start_abort_same();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
